// File: rtl/bcd_result_converter.sv
// bcd_result_converter
// Converts a 16-bit multiplier product into sign plus five BCD digits.
// The conversion uses a sequential double-dabble. Each conversion takes a
// fixed 16 cycles from the start sample to the DONE pulse.
// Optional feature: define BCD_SEVSEG_EN to add the registered 42-bit seg
// output. It holds six active-low gfedcba codes: digits 0-4 show bcd, and
// digit 5 shows the minus sign.

module bcd_result_converter #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [15:0] value,
    output logic        busy,
    output logic        DONE,
    output logic        sign,
    output logic [19:0] bcd
`ifdef BCD_SEVSEG_EN
    ,
    output logic [41:0] seg
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q;
    logic [19:0] work_q;
    logic [15:0] mag_q;
    logic [3:0]  cnt_q;
    logic        negPend_q;
    logic        busy_q;
    logic        done_q;
    logic        sign_q;
    logic [19:0] bcd_q;

    logic        capSign_d;
    logic [15:0] capMag_d;
    logic [19:0] adjWork;
    logic [19:0] stepWork_d;
    logic [15:0] stepMag_d;
    logic        lastStep;
    logic        capture;

    // Sign and magnitude of the incoming product; -32768 maps cleanly to 0x8000
    always_comb begin
        capSign_d = 1'b0;
        capMag_d  = value;
        if (SIGNED_IN && value[15]) begin
            capSign_d = 1'b1;
            capMag_d  = (~value) + 16'd1;
        end
    end

    // One double-dabble step: correct digits >= 5, then shift the magnitude MSB in
    always_comb begin
        adjWork = work_q;
        for (int i = 0; i < 5; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adjWork[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        stepWork_d = {adjWork[18:0], mag_q[15]};
        stepMag_d  = {mag_q[14:0], 1'b0};
    end

    // A new capture is accepted from IDLE or FIN only; start in CONV is ignored
    always_comb begin
        lastStep = (state_q == CONV) && (cnt_q == 4'd15);
        capture  = start && ((state_q == IDLE) || (state_q == FIN));
    end

    // Main controller: state, datapath registers and registered Moore outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            work_q    <= 20'd0;
            mag_q     <= 16'd0;
            cnt_q     <= 4'd0;
            negPend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sign_q    <= 1'b0;
            bcd_q     <= 20'd0;
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    if (capture) begin
                        work_q    <= 20'd0;
                        mag_q     <= capMag_d;
                        cnt_q     <= 4'd0;
                        negPend_q <= capSign_d;
                        state_q   <= CONV;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end else begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                    end
                end
                CONV: begin
                    work_q <= stepWork_d;
                    mag_q  <= stepMag_d;
                    cnt_q  <= cnt_q + 4'd1;
                    if (lastStep) begin
                        bcd_q   <= stepWork_d;
                        sign_q  <= negPend_q;
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign DONE = done_q;
    assign sign = sign_q;
    assign bcd  = bcd_q;

`ifdef BCD_SEVSEG_EN
    logic [41:0] seg_q;
    logic [41:0] seg_d;

    function automatic logic [6:0] segDecode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

    // Display codes built from the result being loaded into bcd this cycle
    always_comb begin
        seg_d = 42'h3FF_FFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            seg_d[7*i +: 7] = segDecode(stepWork_d[4*i +: 4]);
        end
        seg_d[41:35] = negPend_q ? 7'b0111111 : 7'b1111111;
    end

    // Display register follows bcd exactly, blank while in reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            seg_q <= 42'h3FF_FFFF_FFFF;
        end else if (lastStep) begin
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_bcd_result_converter.sv
// Testbench for bcd_result_converter: one signed and one unsigned instance
// share the same stimulus. Both are compared against an arithmetic model.

module tb_bcd_result_converter;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic [15:0] value;
    logic        busyS, doneS, signS;
    logic [19:0] bcdS;
    logic        busyU, doneU, signU;
    logic [19:0] bcdU;
`ifdef BCD_SEVSEG_EN
    logic [41:0] segS;
    logic [41:0] segU;
`endif

    int nCompared = 0;
    int nMismatched = 0;

    bcd_result_converter #(.SIGNED_IN(1'b1)) dutSigned (
        .CLK(CLK), .RESET(RESET), .start(start), .value(value),
        .busy(busyS), .DONE(doneS), .sign(signS), .bcd(bcdS)
`ifdef BCD_SEVSEG_EN
        , .seg(segS)
`endif
    );

    bcd_result_converter #(.SIGNED_IN(1'b0)) dutUnsigned (
        .CLK(CLK), .RESET(RESET), .start(start), .value(value),
        .busy(busyU), .DONE(doneU), .sign(signU), .bcd(bcdU)
`ifdef BCD_SEVSEG_EN
        , .seg(segU)
`endif
    );

    // Free-running clock, period 10
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] val;
        logic        expSignS;
        logic [19:0] expBcdS;
        logic        expSignU;
        logic [19:0] expBcdU;
    } vec_t;

    vec_t vecs[8];

    // Reference model: decimal digits by plain division
    function automatic void refModel(input logic [15:0] v, input bit signedIn,
                                     output logic s, output logic [19:0] b);
        int m;
        if (signedIn && v[15]) begin
            s = 1'b1;
            m = 65536 - int'(v);
        end else begin
            s = 1'b0;
            m = int'(v);
        end
        b = 20'd0;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endfunction

    function automatic logic [41:0] refSeg(input logic s, input logic [19:0] b);
        logic [6:0] lut [10];
        logic [41:0] r;
        lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        r = 42'd0;
        for (int i = 0; i < 5; i++) r[7*i +: 7] = lut[b[4*i +: 4]];
        r[41:35] = s ? 7'b0111111 : 7'b1111111;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle with value v, wait (bounded) for DONE on the signed instance
    task automatic applyStimulus(input logic [15:0] v, output int lat);
        value = v;
        start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) start = 1'b0;
            if (doneS) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic checkConversion(input string tag, input logic [15:0] v);
        int lat;
        logic es, eu;
        logic [19:0] eb, ebu;
        refModel(v, 1'b1, es, eb);
        refModel(v, 1'b0, eu, ebu);
        applyStimulus(v, lat);
        checkOutput({tag, " latency"}, 64'(lat), 64'd17);
        checkOutput({tag, " doneU"}, 64'(doneU), 64'd1);
        checkOutput({tag, " signS"}, 64'(signS), 64'(es));
        checkOutput({tag, " bcdS"}, 64'(bcdS), 64'(eb));
        checkOutput({tag, " signU"}, 64'(signU), 64'(eu));
        checkOutput({tag, " bcdU"}, 64'(bcdU), 64'(ebu));
`ifdef BCD_SEVSEG_EN
        checkOutput({tag, " segS"}, 64'(segS), 64'(refSeg(es, eb)));
        checkOutput({tag, " segU"}, 64'(segU), 64'(refSeg(eu, ebu)));
`endif
        @(negedge CLK);
        checkOutput({tag, " done one cycle"}, 64'(doneS), 64'd0);
    endtask

    initial begin
        int lat;
        int dones;
        logic es;
        logic [19:0] eb, eb2, gotBcd;
        logic [15:0] firstVal, secondVal;

        vecs[0] = '{16'h0006, 1'b0, 20'h00006, 1'b0, 20'h00006};
        vecs[1] = '{16'hFFFA, 1'b1, 20'h00006, 1'b0, 20'h65530};
        vecs[2] = '{16'h8000, 1'b1, 20'h32768, 1'b0, 20'h32768};
        vecs[3] = '{16'hFFFF, 1'b1, 20'h00001, 1'b0, 20'h65535};
        vecs[4] = '{16'h0000, 1'b0, 20'h00000, 1'b0, 20'h00000};
        vecs[5] = '{16'h2710, 1'b0, 20'h10000, 1'b0, 20'h10000};
        vecs[6] = '{16'h7FFF, 1'b0, 20'h32767, 1'b0, 20'h32767};
        vecs[7] = '{16'h8001, 1'b1, 20'h32767, 1'b0, 20'h32769};

        RESET = 1'b0;
        start = 1'b0;
        value = 16'h0;
        #3;
        checkOutput("reset busy", 64'(busyS), 64'd0);
        checkOutput("reset DONE", 64'(doneS), 64'd0);
        checkOutput("reset sign", 64'(signS), 64'd0);
        checkOutput("reset bcd", 64'(bcdS), 64'd0);
`ifdef BCD_SEVSEG_EN
        checkOutput("reset seg", 64'(segS), 64'h3FF_FFFF_FFFF);
`endif
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        $display("[TB] directed vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].val, lat);
            checkOutput("vec latency", 64'(lat), 64'd17);
            checkOutput("vec signS", 64'(signS), 64'(vecs[i].expSignS));
            checkOutput("vec bcdS", 64'(bcdS), 64'(vecs[i].expBcdS));
            checkOutput("vec signU", 64'(signU), 64'(vecs[i].expSignU));
            checkOutput("vec bcdU", 64'(bcdU), 64'(vecs[i].expBcdU));
`ifdef BCD_SEVSEG_EN
            checkOutput("vec segS", 64'(segS), 64'(refSeg(vecs[i].expSignS, vecs[i].expBcdS)));
`endif
            @(negedge CLK);
            checkOutput("vec done pulse", 64'(doneS), 64'd0);
            checkOutput("vec bcd hold", 64'(bcdS), 64'(vecs[i].expBcdS));
        end

        $display("[TB] start pulses during conversion");
        firstVal = 16'hFF85;
        refModel(firstVal, 1'b1, es, eb);
        value = firstVal;
        start = 1'b1;
        dones = 0;
        lat = 0;
        gotBcd = 20'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            start = (k >= 3 && k <= 10) ? k[0] : 1'b0;
            if (k >= 3 && k <= 10) value = 16'($urandom);
            if (doneS) begin
                dones++;
                if (lat == 0) begin
                    lat = k;
                    gotBcd = bcdS;
                end
            end
        end
        checkOutput("ignored start dones", 64'(dones), 64'd1);
        checkOutput("ignored start latency", 64'(lat), 64'd17);
        checkOutput("ignored start bcd", 64'(gotBcd), 64'(eb));
        checkOutput("ignored start sign", 64'(signS), 64'(es));

        $display("[TB] back-to-back conversions");
        firstVal = 16'h04D2;
        secondVal = 16'hF000;
        refModel(firstVal, 1'b1, es, eb);
        refModel(secondVal, 1'b1, es, eb2);
        value = firstVal;
        start = 1'b1;
        dones = 0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (k == 16) value = secondVal;
            if (k == 18) start = 1'b0;
            if (k == 17) begin
                checkOutput("b2b first done", 64'(doneS), 64'd1);
                checkOutput("b2b first bcd", 64'(bcdS), 64'(eb));
            end
            if (k == 18) begin
                checkOutput("b2b no idle busy", 64'(busyS), 64'd1);
                checkOutput("b2b no idle done", 64'(doneS), 64'd0);
            end
            if (k == 25) checkOutput("b2b bcd hold in conv", 64'(bcdS), 64'(eb));
            if (doneS) begin
                dones++;
                if (dones == 2) begin
                    lat = k;
                    break;
                end
            end
        end
        checkOutput("b2b second latency", 64'(lat), 64'd34);
        checkOutput("b2b second bcd", 64'(bcdS), 64'(eb2));
        checkOutput("b2b second sign", 64'(signS), 64'(es));
        @(negedge CLK);

        $display("[TB] reset during conversion");
        value = 16'h3039;
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k == 1) start = 1'b0;
        end
        #2;
        RESET = 1'b0;
        #1;
        checkOutput("midreset busy", 64'(busyS), 64'd0);
        checkOutput("midreset bcd", 64'(bcdS), 64'd0);
        checkOutput("midreset sign", 64'(signS), 64'd0);
        checkOutput("midreset done", 64'(doneS), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        dones = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (doneS) dones++;
        end
        checkOutput("midreset no done", 64'(dones), 64'd0);
        checkConversion("after reset 2710", 16'h2710);

        $display("[TB] randomized conversions");
        for (int i = 0; i < 30; i++) begin
            checkConversion("random", 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
